vram_write_buffer: RTL and testbench

VRAM_WRITE_BUFFER -- requirements
Module: vram_write_buffer

---
 rtl/vram_write_buffer.sv | 109 ++++++++++
 tb/tb_vram_write_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_write_buffer.sv
// vram_write_buffer: buffers CPU byte writes to VRAM in a small FIFO and
// replays them on the GPU write port while the GPU permits VRAM access.
// A CPU write is taken on the rising edge of cpu_cs only, so a held select
// pushes once. Entries drain one per cycle, in order, while vblank is high.
// Build option: define VRAM_WB_ANYTIME_EN to ignore vblank and drain
// whenever the FIFO holds data.
module vram_write_buffer #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_12_5875,
  input  logic                  rst,
  input  logic [7:0]            cpu_data,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic                  cpu_cs,
  input  logic                  vblank,
  output logic [7:0]            vram_data,
  output logic [ADDR_WIDTH-1:0] vram_address,
  output logic                  vram_we,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_WIDTH + 8;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t          state;
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [PW:0]     rd_ptr_nxt;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head_p0;
  logic            cs_d;
  logic            vblank_eff;
  logic            capture_p0;
  logic            pop_p0;
  logic            push_p0;
  logic            last_pop_p0;

  logic            we_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [7:0]      data_p1;

`ifdef VRAM_WB_ANYTIME_EN
  assign vblank_eff = 1'b1;
`else
  assign vblank_eff = vblank;
`endif

  // Pointers carry an extra wrap bit: equal pointers mean empty, equal
  // index with differing wrap bits means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Stage p0: capture, pop and push decisions for this edge.
  assign capture_p0  = cpu_cs & ~cs_d;
  assign pop_p0      = (state == DRAIN) && vblank_eff && !empty;
  assign push_p0     = capture_p0 && (!full || pop_p0);
  assign rd_ptr_nxt  = rd_ptr + (PW+1)'(1);
  assign last_pop_p0 = pop_p0 && !push_p0 && (rd_ptr_nxt == wr_ptr);
  assign head_p0     = mem[rd_ptr[PW-1:0]];

  // FIFO storage: data only, validity is tracked by the pointers.
  always_ff @(posedge clk_12_5875) begin
    if (push_p0) mem[wr_ptr[PW-1:0]] <= {cpu_address, cpu_data};
  end

  // Control: cs edge history, pointers, sticky overflow and drain FSM.
  always_ff @(posedge clk_12_5875 or negedge rst) begin
    if (!rst) begin
      cs_d     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      we_p1    <= 1'b0;
    end else begin
      cs_d  <= cpu_cs;
      we_p1 <= pop_p0;
      if (push_p0) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop_p0) rd_ptr <= rd_ptr_nxt;
      if (capture_p0 && full && !pop_p0) overflow <= 1'b1;
      case (state)
        IDLE:    if (vblank_eff && !empty) state <= DRAIN;
        DRAIN:   if (!vblank_eff || empty || last_pop_p0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: write port address/data, held between strobes.
  always_ff @(posedge clk_12_5875 or negedge rst) begin
    if (!rst) begin
      addr_p1 <= '0;
      data_p1 <= '0;
    end else if (pop_p0) begin
      addr_p1 <= head_p0[EW-1:8];
      data_p1 <= head_p0[7:0];
    end
  end

  assign vram_we      = we_p1;
  assign vram_address = addr_p1;
  assign vram_data    = data_p1;

endmodule

// File: tb/tb_vram_write_buffer.sv
// Bench for vram_write_buffer: directed vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_vram_write_buffer;

  localparam int AW    = 14;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic [7:0]    cpu_data;
  logic [AW-1:0] cpu_address;
  logic          cpu_cs;
  logic          vblank;
  logic [7:0]    vram_data;
  logic [AW-1:0] vram_address;
  logic          vram_we;
  logic          full;
  logic          empty;
  logic          overflow;

  vram_write_buffer #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk_12_5875 (clk),
    .rst         (rst),
    .cpu_data    (cpu_data),
    .cpu_address (cpu_address),
    .cpu_cs      (cpu_cs),
    .vblank      (vblank),
    .vram_data   (vram_data),
    .vram_address(vram_address),
    .vram_we     (vram_we),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  // reference model state
  logic [AW+7:0] m_q [$];
  bit            m_drain;
  bit            m_prev_cs;
  bit            m_we;
  bit            m_ovf;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;

  // observed write-port pulses
  logic [AW-1:0] got_addr [$];
  logic [7:0]    got_data [$];
  int            got_cyc  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drain   = 0;
    m_prev_cs = 0;
    m_we      = 0;
    m_ovf     = 0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  // One clock edge of the specified behaviour: pop first (only when draining,
  // vblank high and data present), then accept a capture if room remains.
  task automatic model_step(input logic cs, input logic [AW-1:0] a, input logic [7:0] d, input logic vb);
    bit vbe;
    int sz0;
    bit pop;
    logic [AW+7:0] e;
`ifdef VRAM_WB_ANYTIME_EN
    vbe = 1;
`else
    vbe = vb;
`endif
    sz0  = m_q.size();
    pop  = m_drain && vbe && (sz0 > 0);
    m_we = 0;
    if (pop) begin
      e      = m_q.pop_front();
      m_we   = 1;
      m_addr = e[AW+7:8];
      m_data = e[7:0];
    end
    if (cs && !m_prev_cs) begin
      if (m_q.size() < DEPTH) m_q.push_back({a, d});
      else m_ovf = 1;
    end
    m_drain   = vbe && (m_drain ? (m_q.size() > 0) : (sz0 > 0));
    m_prev_cs = cs;
  endtask

  task automatic compare_model();
    check("vram_we", 32'(vram_we), 32'(m_we));
    check("vram_address", 32'(vram_address), 32'(m_addr));
    check("vram_data", 32'(vram_data), 32'(m_data));
    check("full", 32'(full), 32'(m_q.size() == DEPTH));
    check("empty", 32'(empty), 32'(m_q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  // Drive inputs, take one edge, advance the model and compare.
  task automatic cycle(input logic cs, input logic [AW-1:0] a, input logic [7:0] d, input logic vb);
    cpu_cs      = cs;
    cpu_address = a;
    cpu_data    = d;
    vblank      = vb;
    @(posedge clk);
    cyc++;
    model_step(cs, a, d, vb);
    #1;
    compare_model();
    if (vram_we) begin
      got_addr.push_back(vram_address);
      got_data.push_back(vram_data);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    cpu_cs      = 1'b0;
    cpu_address = '0;
    cpu_data    = '0;
    vblank      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model();
    rst = 1'b1;
    clear_log();
  endtask

  typedef struct {
    logic          cs;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          vb;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;
    logic          e_empty;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int n;
    int c0;
    bit bad;

    tbl[0]  = '{1'b1, 14'h0010, 8'hA1, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 14'h0011, 8'hA2, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 14'h0012, 8'hA3, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0000, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 14'h0000, 8'h00, 1'b1, 1'b0, 14'h0000, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 14'h0000, 8'h00, 1'b1, 1'b1, 14'h0010, 8'hA1, 1'b0};
    tbl[8]  = '{1'b0, 14'h0000, 8'h00, 1'b1, 1'b1, 14'h0011, 8'hA2, 1'b0};
    tbl[9]  = '{1'b0, 14'h0000, 8'h00, 1'b1, 1'b1, 14'h0012, 8'hA3, 1'b1};
    tbl[10] = '{1'b0, 14'h0000, 8'h00, 1'b1, 1'b0, 14'h0012, 8'hA3, 1'b1};
    tbl[11] = '{1'b0, 14'h0000, 8'h00, 1'b0, 1'b0, 14'h0012, 8'hA3, 1'b1};

    rst = 1'b1;
    do_reset();
    check("reset empty", 32'(empty), 32'd1);
    check("reset full", 32'(full), 32'd0);
    check("reset vram_we", 32'(vram_we), 32'd0);

`ifndef VRAM_WB_ANYTIME_EN
    // three buffered writes during active video, then a drain
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].cs, tbl[i].addr, tbl[i].data, tbl[i].vb);
      check($sformatf("tbl[%0d] we", i), 32'(vram_we), 32'(tbl[i].e_we));
      check($sformatf("tbl[%0d] addr", i), 32'(vram_address), 32'(tbl[i].e_addr));
      check($sformatf("tbl[%0d] data", i), 32'(vram_data), 32'(tbl[i].e_data));
      check($sformatf("tbl[%0d] empty", i), 32'(empty), 32'(tbl[i].e_empty));
    end

    // held select pushes once; strobe lands two edges after capture
    do_reset();
    c0 = cyc + 1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 14'h0100, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 14'h0000, 8'h00, 1'b1);
    check("held cs pulse count", 32'(got_cyc.size()), 32'd1);
    if (got_cyc.size() > 0) begin
      check("held cs latency", 32'(got_cyc[0] - c0), 32'd2);
      check("held cs addr", 32'(got_addr[0]), 32'h0100);
      check("held cs data", 32'(got_data[0]), 32'h5A);
    end

    // overflow: DEPTH+1 pushes, last one dropped
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      cycle(1'b1, AW'(14'h0300 + i), 8'(i), 1'b0);
      cycle(1'b0, 14'h0000, 8'h00, 1'b0);
      if (i == DEPTH - 1) begin
        check("full after DEPTH", 32'(full), 32'd1);
        check("no overflow at DEPTH", 32'(overflow), 32'd0);
      end
    end
    check("overflow after DEPTH+1", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH + 6; i++) cycle(1'b0, 14'h0000, 8'h00, 1'b1);
    check("overflow drain count", 32'(got_cyc.size()), 32'(DEPTH));
    bad = 0;
    for (int i = 0; i < got_cyc.size(); i++)
      if (got_addr[i] != AW'(14'h0300 + i) || got_data[i] != 8'(i)) bad = 1;
    check("overflow drain order", 32'(bad), 32'd0);
    check("overflow sticky", 32'(overflow), 32'd1);
    check("empty after drain", 32'(empty), 32'd1);

    // short vblank window, then resume
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, AW'(14'h0400 + i), 8'(8'h40 + i), 1'b0);
      cycle(1'b0, 14'h0000, 8'h00, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 14'h0000, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 14'h0000, 8'h00, 1'b0);
    check("short window at most 3", 32'(got_cyc.size() <= 3), 32'd1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 14'h0000, 8'h00, 1'b1);
    check("resume total", 32'(got_cyc.size()), 32'd8);
    bad = 0;
    for (int i = 0; i < got_cyc.size(); i++)
      if (got_addr[i] != AW'(14'h0400 + i) || got_data[i] != 8'(8'h40 + i)) bad = 1;
    check("resume order", 32'(bad), 32'd0);

    // asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, AW'(14'h0500 + i), 8'(i), 1'b0);
      cycle(1'b0, 14'h0000, 8'h00, 1'b0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 14'h0000, 8'h00, 1'b1);
    check("pending before reset", 32'(DEPTH - 0) - 32'(0) == 32'(DEPTH) ? 32'(m_q.size()) : 32'd0, 32'd6);
    check("we before reset", 32'(vram_we), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async reset we", 32'(vram_we), 32'd0);
    check("async reset empty", 32'(empty), 32'd1);
    check("async reset overflow", 32'(overflow), 32'd0);
    check("async reset addr", 32'(vram_address), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_log();
    for (int i = 0; i < 10; i++) cycle(1'b0, 14'h0000, 8'h00, 1'b1);
    check("no writes after reset", 32'(got_cyc.size()), 32'd0);
`else
    // drain ignores vblank
    do_reset();
    c0 = cyc + 1;
    cycle(1'b1, 14'h0200, 8'h3C, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 14'h0000, 8'h00, 1'b0);
    check("anytime pulse count", 32'(got_cyc.size()), 32'd1);
    if (got_cyc.size() > 0) begin
      check("anytime latency", 32'(got_cyc[0] - c0), 32'd2);
      check("anytime addr", 32'(got_addr[0]), 32'h0200);
      check("anytime data", 32'(got_data[0]), 32'h3C);
    end
`endif

    // randomized traffic against the model, with one reset midway
    do_reset();
    begin
      logic vb_r;
      vb_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 11) == 0) vb_r = ~vb_r;
        if (i == 1500) begin
          do_reset();
          vb_r = 1'b0;
        end
        cycle(logic'($urandom_range(0, 1)), AW'($urandom), 8'($urandom), vb_r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
